uart_rx_param: RTL and testbench

Parametrised UART receiver; next generation of the fixed 8N1 receiver. Adds configurable data width, parity, stop bits and oversampling, an input synchroniser, 3-sample majority voting, error reporting, and a valid/ready output holding register. The whole block runs on the system clock; `baud_tick` is a one-cycle enable from the baud rate generator at OVERSAMPLE × baud rate.

---
 rtl/uart_pkg.sv | 44 ++++
 rtl/uart_rx_sampler.sv | 63 ++++++
 rtl/uart_rx_param.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and parameter-legality limits, used by the receiver and
// the parametrised transmitter that follows it.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  localparam int unsigned UART_DATA_BITS_MIN  = 5;
  localparam int unsigned UART_DATA_BITS_MAX  = 9;
  localparam int unsigned UART_STOP_BITS_MIN  = 1;
  localparam int unsigned UART_STOP_BITS_MAX  = 2;
  localparam int unsigned UART_OVERSAMPLE_MIN = 8;
  localparam int unsigned UART_OVERSAMPLE_MAX = 32;
  localparam int unsigned UART_SYNC_MIN       = 2;

  function automatic bit uart_cfg_legal(input int unsigned data_bits,
                                        input int unsigned parity_mode,
                                        input int unsigned stop_bits,
                                        input int unsigned oversample,
                                        input int unsigned sync_stages);
    return (data_bits >= UART_DATA_BITS_MIN) && (data_bits <= UART_DATA_BITS_MAX) &&
           (parity_mode <= 2) &&
           (stop_bits >= UART_STOP_BITS_MIN) && (stop_bits <= UART_STOP_BITS_MAX) &&
           (oversample >= UART_OVERSAMPLE_MIN) && (oversample <= UART_OVERSAMPLE_MAX) &&
           (oversample % 2 == 0) && (sync_stages >= UART_SYNC_MIN);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rx synchroniser, per-bit oversample counter and 3-sample majority vote.
// bit_strobe_o fires on the tick that takes the third sample; bit_val_o is valid with it.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  input  logic baud_tick_i,
  input  logic active_i,
  input  logic clear_i,
  output logic rx_s_o,
  output logic bit_val_o,
  output logic bit_strobe_o
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned M  = OVERSAMPLE / 2;
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_S0   = TW'(M - 1);
  localparam logic [TW-1:0] T_S1   = TW'(M);
  localparam logic [TW-1:0] T_S2   = TW'(M + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [TW-1:0]          tick_q, tick_d;
  logic [1:0]             samp_q, samp_d;
  logic                   tick_en;

  assign rx_s_o  = sync_q[SYNC_STAGES-1];
  assign tick_en = active_i & baud_tick_i;

  always_comb begin
    tick_d = tick_q;
    samp_d = samp_q;
    if (clear_i) begin
      tick_d = '0;
    end else if (tick_en) begin
      tick_d = (tick_q == T_LAST) ? '0 : tick_q + 1'b1;
      if (tick_q == T_S0) samp_d[0] = rx_s_o;
      if (tick_q == T_S1) samp_d[1] = rx_s_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      tick_q <= '0;
      samp_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      tick_q <= tick_d;
      samp_q <= samp_d;
    end
  end

  // Third sample is taken live on the strobe tick rather than stored.
  assign bit_strobe_o = tick_en & (tick_q == T_S2);
  assign bit_val_o    = maj3(samp_q[0], samp_q[1], rx_s_o);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, shift register, parity/stop checks
// and a one-entry valid/ready holding register with overrun reporting.
//
// state        | meaning
// ST_IDLE      | waiting for rx_s low with rx_enable high
// ST_START     | verifying start bit at its centre; high majority = false start
// ST_DATA      | shifting in DATA_BITS bits, LSB first
// ST_PARITY    | checking the parity bit
// ST_STOP      | checking STOP_BITS stop bits; frame completes on the last one
// ST_WAIT_HIGH | after a framing error, waiting for the line to return high
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  input  logic                 rx_enable_i,
  input  logic                 baud_tick_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 parity_error_o,
  output logic                 framing_error_o,
  output logic                 overrun_error_o
);

  localparam parity_mode_e PMODE    = parity_mode_e'(2'(PARITY_MODE));
  localparam logic [3:0]   BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic         STP_LAST = 1'(STOP_BITS - 1);

  rx_state_e state_q, state_d;

  logic                 rx_s, bit_val, bit_strobe;
  logic                 active, start_det, shift_en, par_en, stop_en, done;
  logic [DATA_BITS-1:0] shift_q;
  logic [3:0]           bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 pe_q, fe_q, fe_final, parity_bad, deliver;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, pe_out_q, fe_out_q, ovr_q;

  uart_rx_sampler #(
    .OVERSAMPLE  (OVERSAMPLE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_i         (rx_i),
    .baud_tick_i  (baud_tick_i),
    .active_i     (active),
    .clear_i      (start_det),
    .rx_s_o       (rx_s),
    .bit_val_o    (bit_val),
    .bit_strobe_o (bit_strobe)
  );

  assign fe_final   = fe_q | ~bit_val;
  assign parity_bad = (PMODE == PAR_ODD) ? ~(^shift_q ^ bit_val) : (^shift_q ^ bit_val);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (!rx_s && rx_enable_i) state_d = ST_START;
      ST_START:     if (bit_strobe) state_d = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:      if (bit_strobe && bit_cnt_q == BIT_LAST)
                      state_d = (PMODE != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (bit_strobe) state_d = ST_STOP;
      // Leaving at mid-stop-bit lets IDLE catch a start edge right after it.
      ST_STOP:      if (bit_strobe && stop_cnt_q == STP_LAST)
                      state_d = fe_final ? ST_WAIT_HIGH : ST_IDLE;
      ST_WAIT_HIGH: if (rx_s) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    active    = 1'b0;
    start_det = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_en   = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE:   start_det = !rx_s && rx_enable_i;
      ST_START:  active = 1'b1;
      ST_DATA:   begin active = 1'b1; shift_en = bit_strobe; end
      ST_PARITY: begin active = 1'b1; par_en = bit_strobe; end
      ST_STOP:   begin
        active  = 1'b1;
        stop_en = bit_strobe;
        done    = bit_strobe && (stop_cnt_q == STP_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      if (start_det) begin
        bit_cnt_q  <= '0;
        stop_cnt_q <= 1'b0;
        pe_q       <= 1'b0;
        fe_q       <= 1'b0;
      end
      if (shift_en) begin
        shift_q   <= {bit_val, shift_q[DATA_BITS-1:1]};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (par_en) pe_q <= parity_bad;
      if (stop_en) begin
        fe_q       <= fe_final;
        stop_cnt_q <= stop_cnt_q + 1'b1;
      end
    end
  end

  assign deliver = done && (!valid_q || rx_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      pe_out_q <= 1'b0;
      fe_out_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= done && valid_q && !rx_ready_i;
      if (deliver) begin
        data_q   <= shift_q;
        pe_out_q <= pe_q;
        fe_out_q <= fe_final;
        valid_q  <= 1'b1;
      end else if (valid_q && rx_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_data_o       = data_q;
  assign rx_valid_o      = valid_q;
  assign parity_error_o  = pe_out_q;
  assign framing_error_o = fe_out_q;
  assign overrun_error_o = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench: an 8N1 receiver (a) and a 7E2 receiver (b) on a shared
// clock, reset and baud tick (one tick every 4 clocks, 16 ticks per bit).
module tb_uart_rx_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic en = 1'b1;
  logic tick = 1'b0;
  logic rdy_a = 1'b1, rdy_b = 1'b1;

  logic [7:0] dat_a;
  logic [6:0] dat_b;
  logic       vld_a, pe_a, fe_a, ov_a;
  logic       vld_b, pe_b, fe_b, ov_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  int tdiv = 0;
  always @(posedge clk) begin
    tdiv <= (tdiv == 3) ? 0 : tdiv + 1;
    tick <= (tdiv == 3);
  end

  uart_rx_param u_a (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_a), .rx_enable_i(en), .baud_tick_i(tick),
    .rx_data_o(dat_a), .rx_valid_o(vld_a), .rx_ready_i(rdy_a),
    .parity_error_o(pe_a), .framing_error_o(fe_a), .overrun_error_o(ov_a)
  );

  uart_rx_param #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_b), .rx_enable_i(en), .baud_tick_i(tick),
    .rx_data_o(dat_b), .rx_valid_o(vld_b), .rx_ready_i(rdy_b),
    .parity_error_o(pe_b), .framing_error_o(fe_b), .overrun_error_o(ov_b)
  );

  // Handshake monitors: record accepted words and count valid cycles / overruns.
  int acc_a = 0, vcyc_a = 0, ovr_a = 0;
  int acc_b = 0, ovr_b = 0;
  logic [7:0] ld_a = '0;
  logic [6:0] ld_b = '0;
  logic lpe_a = 1'b0, lfe_a = 1'b0, lpe_b = 1'b0, lfe_b = 1'b0;

  always @(negedge clk) begin
    if (vld_a) vcyc_a++;
    if (ov_a) ovr_a++;
    if (vld_a && rdy_a) begin
      acc_a++; ld_a = dat_a; lpe_a = pe_a; lfe_a = fe_a;
    end
    if (ov_b) ovr_b++;
    if (vld_b && rdy_b) begin
      acc_b++; ld_b = dat_b; lpe_b = pe_b; lfe_b = fe_b;
    end
  end

  task automatic line(input int d, input logic v, input int ticks);
    if (d == 0) rx_a = v;
    else        rx_b = v;
    repeat (ticks * 4) @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [8:0] data, input int nbits,
                      input int par, input int nstop, input logic sv);
    line(d, 1'b0, 16);
    for (int i = 0; i < nbits; i++) line(d, data[i], 16);
    if (par >= 0) line(d, (par != 0), 16);
    for (int s = 0; s < nstop; s++) line(d, sv, 16);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (dat_a !== 8'h00) begin bad++; $display("FAIL reset_data_a got=%h want=00", dat_a); end
    total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL reset_valid_a got=%b want=0", vld_a); end
    total++; if ({pe_a, fe_a, ov_a} !== 3'b000) begin bad++; $display("FAIL reset_flags_a got=%b want=000", {pe_a, fe_a, ov_a}); end
    total++; if ({vld_b, pe_b, fe_b, ov_b} !== 4'b0000) begin bad++; $display("FAIL reset_b got=%b want=0000", {vld_b, pe_b, fe_b, ov_b}); end
    @(posedge clk); #1 rst_n = 1'b1;
    line(0, 1'b1, 4);
  endtask

  task automatic test_8n1_basic;
    int a0 = acc_a, v0 = vcyc_a;
    send(0, 9'h0A5, 8, -1, 1, 1'b1);
    line(0, 1'b1, 8);
    total++; if (acc_a - a0 !== 1) begin bad++; $display("FAIL a5_count got=%0d want=1", acc_a - a0); end
    total++; if (ld_a !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h want=a5", ld_a); end
    total++; if ({lpe_a, lfe_a} !== 2'b00) begin bad++; $display("FAIL a5_flags got=%b want=00", {lpe_a, lfe_a}); end
    total++; if (vcyc_a - v0 !== 1) begin bad++; $display("FAIL a5_valid_width got=%0d want=1", vcyc_a - v0); end
  endtask

  task automatic test_7e2_parity;
    int b0 = acc_b;
    send(1, 9'h041, 7, 0, 2, 1'b1);
    line(1, 1'b1, 8);
    total++; if (acc_b - b0 !== 1) begin bad++; $display("FAIL 7e2_count1 got=%0d want=1", acc_b - b0); end
    total++; if (ld_b !== 7'h41) begin bad++; $display("FAIL 7e2_data1 got=%h want=41", ld_b); end
    total++; if ({lpe_b, lfe_b} !== 2'b00) begin bad++; $display("FAIL 7e2_flags1 got=%b want=00", {lpe_b, lfe_b}); end
    send(1, 9'h041, 7, 1, 2, 1'b1);
    line(1, 1'b1, 8);
    total++; if (acc_b - b0 !== 2) begin bad++; $display("FAIL 7e2_count2 got=%0d want=2", acc_b - b0); end
    total++; if (ld_b !== 7'h41) begin bad++; $display("FAIL 7e2_data2 got=%h want=41", ld_b); end
    total++; if ({lpe_b, lfe_b} !== 2'b10) begin bad++; $display("FAIL 7e2_flags2 got=%b want=10", {lpe_b, lfe_b}); end
  endtask

  task automatic test_false_start;
    int a0 = acc_a;
    line(0, 1'b0, 5);
    line(0, 1'b1, 24);
    total++; if (acc_a !== a0) begin bad++; $display("FAIL glitch_no_frame got=%0d want=%0d", acc_a, a0); end
    send(0, 9'h03C, 8, -1, 1, 1'b1);
    line(0, 1'b1, 8);
    total++; if (acc_a - a0 !== 1) begin bad++; $display("FAIL glitch_next_count got=%0d want=1", acc_a - a0); end
    total++; if (ld_a !== 8'h3C) begin bad++; $display("FAIL glitch_next_data got=%h want=3c", ld_a); end
  endtask

  task automatic test_enable_gate;
    int a0 = acc_a;
    en = 1'b0;
    send(0, 9'h05A, 8, -1, 1, 1'b1);
    line(0, 1'b1, 8);
    total++; if (acc_a !== a0) begin bad++; $display("FAIL enable_gate got=%0d want=%0d", acc_a, a0); end
    en = 1'b1;
  endtask

  task automatic test_framing;
    int a0 = acc_a;
    send(0, 9'h000, 8, -1, 1, 1'b0);
    line(0, 1'b0, 40);
    total++; if (acc_a - a0 !== 1) begin bad++; $display("FAIL fe_count got=%0d want=1", acc_a - a0); end
    total++; if (ld_a !== 8'h00) begin bad++; $display("FAIL fe_data got=%h want=00", ld_a); end
    total++; if (lfe_a !== 1'b1) begin bad++; $display("FAIL fe_flag got=%b want=1", lfe_a); end
    line(0, 1'b1, 16);
    send(0, 9'h055, 8, -1, 1, 1'b1);
    line(0, 1'b1, 8);
    total++; if (acc_a - a0 !== 2) begin bad++; $display("FAIL fe_next_count got=%0d want=2", acc_a - a0); end
    total++; if ({ld_a, lfe_a} !== {8'h55, 1'b0}) begin bad++; $display("FAIL fe_next got=%h/%b want=55/0", ld_a, lfe_a); end
  endtask

  task automatic test_back_to_back_overrun;
    int a0, o0;
    @(posedge clk); #1 rdy_a = 1'b0;
    a0 = acc_a; o0 = ovr_a;
    send(0, 9'h011, 8, -1, 1, 1'b1);
    send(0, 9'h022, 8, -1, 1, 1'b1);
    line(0, 1'b1, 8);
    total++; if (vld_a !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", vld_a); end
    total++; if (dat_a !== 8'h11) begin bad++; $display("FAIL ovr_data got=%h want=11", dat_a); end
    total++; if (ovr_a - o0 !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=1", ovr_a - o0); end
    rdy_a = 1'b1;
    @(posedge clk); #1;
    total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", vld_a); end
    total++; if (acc_a - a0 !== 1 || ld_a !== 8'h11) begin bad++; $display("FAIL ovr_accept got=%0d/%h want=1/11", acc_a - a0, ld_a); end
  endtask

  task automatic test_reset_mid_frame;
    int a0 = acc_a;
    line(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) line(0, 1'b1, 16);
    line(0, 1'b1, 8);
    rst_n = 1'b0;
    #1;
    total++; if (dat_a !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h want=00", dat_a); end
    total++; if ({vld_a, pe_a, fe_a, ov_a} !== 4'b0000) begin bad++; $display("FAIL midrst_outs got=%b want=0000", {vld_a, pe_a, fe_a, ov_a}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    line(0, 1'b1, 16);
    total++; if (acc_a !== a0) begin bad++; $display("FAIL midrst_nothing got=%0d want=%0d", acc_a, a0); end
    send(0, 9'h081, 8, -1, 1, 1'b1);
    line(0, 1'b1, 8);
    total++; if (acc_a - a0 !== 1) begin bad++; $display("FAIL midrst_next_count got=%0d want=1", acc_a - a0); end
    total++; if ({ld_a, lpe_a, lfe_a} !== {8'h81, 2'b00}) begin bad++; $display("FAIL midrst_next got=%h/%b%b want=81/00", ld_a, lpe_a, lfe_a); end
  endtask

  initial begin
    test_reset();
    test_8n1_basic();
    test_7e2_parity();
    test_false_start();
    test_enable_gate();
    test_framing();
    test_back_to_back_overrun();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
